// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// drives the producer side of the IF/ID latch. If decode is stalled when a
// fetch completes, the fetched word is parked in a one-entry hold buffer.
// Redirects squash wrong-path fetches. Halt stops fetching until reset.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] npc_out,
    output logic [31:0] instr_out,
    output logic        latch_stall,
    output logic        latch_bubble,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_npc;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_avail;
    logic [31:0] w_src_instr;
    logic [31:0] w_src_npc;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = {redirect_pc[31:2], 2'b00};
    assign imemaddr          = r_pc;

    // Latch control and delivered-instruction mux; reset forces a bubble.
    always_comb begin
        imemREN      = 1'b0;
        halted       = 1'b0;
        latch_bubble = 1'b1;
        latch_stall  = 1'b0;
        npc_out      = 32'd0;
        instr_out    = 32'd0;
        w_avail      = 1'b0;
        w_src_instr  = 32'd0;
        w_src_npc    = 32'd0;
        if (!RST) begin
            case (r_state)
                S_FETCH: begin
                    imemREN = 1'b1;
                    // Data arriving alongside halt is discarded, so it is not
                    // offered to the latch.
                    w_avail     = ihit & ~halt;
                    w_src_instr = imemload;
                    w_src_npc   = w_pc_plus4;
                end
                S_HOLD: begin
                    w_avail     = ~halt;
                    w_src_instr = r_buf_instr;
                    w_src_npc   = r_buf_npc;
                end
                S_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    w_avail = 1'b0;
                end
            endcase

            if (redirect) begin
                latch_bubble = 1'b1;
                latch_stall  = 1'b0;
            end else if (stall_in) begin
                latch_bubble = 1'b0;
                latch_stall  = 1'b1;
            end else if (w_avail) begin
                latch_bubble = 1'b0;
                latch_stall  = 1'b0;
            end else begin
                latch_bubble = 1'b1;
                latch_stall  = 1'b0;
            end

            // Payload is meaningless under a bubble; keep it at zero then.
            if (!latch_bubble) begin
                npc_out   = w_src_npc;
                instr_out = w_src_instr;
            end
        end
    end

    // PC, state and hold-buffer update; redirect beats halt, stall and ihit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_FETCH;
            r_pc        <= PC_INIT;
            r_buf_instr <= 32'd0;
            r_buf_npc   <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        r_pc <= w_redirect_target;
                    end else if (halt) begin
                        r_state <= S_HALTED;
                    end else if (ihit) begin
                        r_pc <= w_pc_plus4;
                        if (stall_in) begin
                            r_buf_instr <= imemload;
                            r_buf_npc   <= w_pc_plus4;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc        <= w_redirect_target;
                        r_buf_instr <= 32'd0;
                        r_buf_npc   <= 32'd0;
                        r_state     <= S_FETCH;
                    end else if (halt) begin
                        r_buf_instr <= 32'd0;
                        r_buf_npc   <= 32'd0;
                        r_state     <= S_HALTED;
                    end else if (!stall_in) begin
                        // The latch captures the buffer on this edge.
                        r_state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (redirect) begin
                        r_pc <= w_redirect_target;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
